// File: rtl/seq_alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_alu: multi-cycle ALU (shift-add MUL, restoring DIV) with handshake |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_dbz
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_DIV  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_MUL  = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_SHR  = 5'd8;
  localparam logic [4:0] OP_SHRA = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ROR  = 5'd11;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;

  localparam logic [SHW:0]   WIDTH_EXT = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] LAST_CNT  = SHW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic             accept;
  logic             needs_iter;
  logic             last_step;
  logic [SHW-1:0]   count;
  logic             is_mul;
  logic [WIDTH-1:0] m_opnd;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;

  // ---------------------------------------------------------------- single-cycle datapath
  logic [SHW-1:0]          amt;
  logic [SHW:0]            inv_amt;
  logic [WIDTH-1:0]        sub_lhs;
  logic [WIDTH-1:0]        sub_rhs;
  logic [WIDTH:0]          add_ext;
  logic [WIDTH:0]          sub_ext;
  logic [WIDTH:0]          shl_ext;
  logic [WIDTH:0]          shr_ext;
  logic signed [WIDTH:0]   sra_ext;
  logic [WIDTH-1:0]        rol_res;
  logic [WIDTH-1:0]        ror_res;

  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_c;
  logic             sc_v;
  logic             sc_z;
  logic             sc_n;
  logic             sc_dbz;

  assign amt     = b[SHW-1:0];
  assign inv_amt = WIDTH_EXT - {1'b0, amt};
  assign sub_lhs = (op == OP_NEG) ? '0 : a;
  assign sub_rhs = (op == OP_NEG) ? a : b;
  assign add_ext = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the unsigned borrow.
  assign sub_ext = {1'b0, sub_lhs} - {1'b0, sub_rhs};
  // Guard bits on either side catch the last bit shifted out (0 for amount 0).
  assign shl_ext = {1'b0, a} << amt;
  assign shr_ext = {a, 1'b0} >> amt;
  assign sra_ext = $signed({a, 1'b0}) >>> amt;
  assign rol_res = (a << amt) | (a >> inv_amt);
  assign ror_res = (a >> amt) | (a << inv_amt);

  always_comb begin
    sc_lo  = a;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dbz = 1'b0;
    case (op)
      OP_ADD: begin
        sc_lo = add_ext[WIDTH-1:0];
        sc_c  = add_ext[WIDTH];
        sc_v  = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_NEG: begin
        sc_lo = sub_ext[WIDTH-1:0];
        sc_c  = sub_ext[WIDTH];
        sc_v  = (sub_lhs[WIDTH-1] != sub_rhs[WIDTH-1]) &&
                (sub_ext[WIDTH-1] != sub_lhs[WIDTH-1]);
      end
      OP_DIV: begin
        // Only reached for a zero divisor; non-zero divisors iterate.
        sc_lo  = '1;
        sc_hi  = a;
        sc_dbz = 1'b1;
      end
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_XOR:  sc_lo = a ^ b;
      OP_SHL: begin
        sc_lo = shl_ext[WIDTH-1:0];
        sc_c  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        sc_lo = shr_ext[WIDTH:1];
        sc_c  = shr_ext[0];
      end
      OP_SHRA: begin
        sc_lo = sra_ext[WIDTH:1];
        sc_c  = sra_ext[0];
      end
      OP_ROL:  sc_lo = rol_res;
      OP_ROR:  sc_lo = ror_res;
      OP_NOT:  sc_lo = ~a;
      default: sc_lo = a;
    endcase
    sc_z = (op == OP_DIV) ? 1'b0 : (sc_lo == '0);
    sc_n = (op == OP_DIV) ? 1'b1 : sc_lo[WIDTH-1];
  end

  // ---------------------------------------------------------------- iterative datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, m_opnd} : '0);
    rem_sh  = {work_hi, work_lo[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, m_opnd});
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else begin
      // A successful trial subtract always fits in WIDTH bits.
      step_hi = div_ge ? (rem_sh[WIDTH-1:0] - m_opnd) : rem_sh[WIDTH-1:0];
      step_lo = {work_lo[WIDTH-2:0], div_ge};
    end
  end

  assign needs_iter = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = needs_iter ? ITER : DONE;
        end
      end
      ITER: begin
        if (count == '0) begin
          last_step = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      is_mul    <= 1'b0;
      m_opnd    <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      result_lo <= '0;
      result_hi <= '0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_dbz  <= 1'b0;
    end else if (accept) begin
      if (needs_iter) begin
        count   <= LAST_CNT;
        is_mul  <= (op == OP_MUL);
        m_opnd  <= (op == OP_MUL) ? a : b;
        work_hi <= '0;
        work_lo <= (op == OP_MUL) ? b : a;
      end else begin
        result_lo <= sc_lo;
        result_hi <= sc_hi;
        flag_c    <= sc_c;
        flag_v    <= sc_v;
        flag_z    <= sc_z;
        flag_n    <= sc_n;
        flag_dbz  <= sc_dbz;
      end
    end else if (state == ITER) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
      count   <= count - 1'b1;
      if (last_step) begin
        result_lo <= step_lo;
        result_hi <= step_hi;
        flag_c    <= 1'b0;
        flag_v    <= 1'b0;
        flag_dbz  <= 1'b0;
        flag_z    <= is_mul ? ({step_hi, step_lo} == '0) : (step_lo == '0);
        flag_n    <= is_mul ? step_hi[WIDTH-1] : step_lo[WIDTH-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_seq_alu: directed + randomized bench with a behavioural ALU model   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        flag_c, flag_v, flag_z, flag_n, flag_dbz;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid),
    .result_lo(result_lo), .result_hi(result_hi),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .flag_dbz(flag_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] flags;
  assign flags = {flag_c, flag_v, flag_z, flag_n, flag_dbz};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one op: flags packed as {c,v,z,n,dbz}
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  fl;
    int          lat;
  } res_t;

  function automatic res_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    logic [63:0] p;
    longint      t;
    int          s;
    logic        c, v, z, n, dbz;
    s = int'(y[4:0]);
    r.lo = x; r.hi = 32'd0; r.lat = 1;
    c = 1'b0; v = 1'b0; dbz = 1'b0; p = 64'd0; t = 0;
    case (o)
      5'd0: begin
        r.lo = x + y;
        c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
        t = longint'($signed(x)) + longint'($signed(y));
        v = (t != longint'($signed(r.lo)));
      end
      5'd1: begin
        r.lo = x - y;
        c = (x < y);
        t = longint'($signed(x)) - longint'($signed(y));
        v = (t != longint'($signed(r.lo)));
      end
      5'd2: begin
        if (y == 32'd0) begin
          r.lo = 32'hFFFF_FFFF; r.hi = x; dbz = 1'b1;
        end else begin
          r.lo = x / y; r.hi = x % y; r.lat = 33;
        end
      end
      5'd3: r.lo = x & y;
      5'd4: r.lo = x | y;
      5'd5: r.lo = x ^ y;
      5'd6: begin
        p = {32'd0, x} * {32'd0, y};
        r.lo = p[31:0]; r.hi = p[63:32]; r.lat = 33;
      end
      5'd7: begin
        r.lo = x << s;
        c = (s != 0) ? x[32-s] : 1'b0;
      end
      5'd8: begin
        r.lo = x >> s;
        c = (s != 0) ? x[s-1] : 1'b0;
      end
      5'd9: begin
        r.lo = $signed(x) >>> s;
        c = (s != 0) ? x[s-1] : 1'b0;
      end
      5'd10: r.lo = (s != 0) ? ((x << s) | (x >> (32 - s))) : x;
      5'd11: r.lo = (s != 0) ? ((x >> s) | (x << (32 - s))) : x;
      5'd12: begin
        r.lo = 32'd0 - x;
        c = (x != 32'd0);
        t = -longint'($signed(x));
        v = (t != longint'($signed(r.lo)));
      end
      5'd13: r.lo = ~x;
      default: r.lo = x;
    endcase
    if (o == 5'd6) begin
      z = (p == 64'd0); n = r.hi[31];
    end else if (dbz) begin
      z = 1'b0; n = 1'b1;
    end else begin
      z = (r.lo == 32'd0); n = r.lo[31];
    end
    r.fl = {c, v, z, n, dbz};
    return r;
  endfunction

  // Model state: cycles remaining until the result is presented (0 = idle)
  int          m_cnt = 0;
  res_t        pend;
  logic [31:0] e_lo = '0;
  logic [31:0] e_hi = '0;
  logic [4:0]  e_fl = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      e_lo = '0; e_hi = '0; e_fl = '0;
    end else begin
      if (m_cnt == 0) begin
        if (in_valid) begin
          pend  = model(op, a, b);
          m_cnt = pend.lat;
        end
      end else begin
        m_cnt--;
      end
      if (m_cnt == 1) begin
        e_lo = pend.lo; e_hi = pend.hi; e_fl = pend.fl;
      end
    end
  end

  always @(negedge clk) begin
    chk("mon_in_ready",  {63'd0, in_ready},  {63'd0, m_cnt == 0});
    chk("mon_out_valid", {63'd0, out_valid}, {63'd0, m_cnt == 1});
    chk("mon_lo",        {32'd0, result_lo}, {32'd0, e_lo});
    chk("mon_hi",        {32'd0, result_hi}, {32'd0, e_hi});
    chk("mon_flags",     {59'd0, flags},     {59'd0, e_fl});
  end

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = hold; op = 5'd0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
  endtask

  task automatic run(input string nm, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input bit hold, input int e_lat, input logic [31:0] elo, input logic [31:0] ehi,
                     input logic [4:0] efl);
    int lat;
    issue(o, x, y, hold);
    wait_done(lat);
    chk({nm, "_lat"},   64'(lat), 64'(e_lat));
    chk({nm, "_lo"},    {32'd0, result_lo}, {32'd0, elo});
    chk({nm, "_hi"},    {32'd0, result_hi}, {32'd0, ehi});
    chk({nm, "_flags"}, {59'd0, flags},     {59'd0, efl});
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_seen;
    rst_n = 1'b0; in_valid = 1'b0; op = 5'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_lo",        {32'd0, result_lo}, 64'd0);
    chk("rst_hi",        {32'd0, result_hi}, 64'd0);
    chk("rst_flags",     {59'd0, flags},     64'd0);
    #2 rst_n = 1'b1;

    run("add_carry", 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1,  32'h0000_0000, 32'h0, 5'b10100);
    run("add_ovf",   5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1,  32'h8000_0000, 32'h0, 5'b01010);
    run("mul_max",   5'd6,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33, 32'h0000_0001, 32'hFFFF_FFFE, 5'b00010);
    run("div_100_7", 5'd2,  32'd100,       32'd7,         1'b0, 33, 32'd14,        32'd2,         5'b00000);
    run("div_zero",  5'd2,  32'd5,         32'd0,         1'b0, 1,  32'hFFFF_FFFF, 32'd5,         5'b00011);
    run("shra",      5'd9,  32'h8000_0000, 32'h0000_0021, 1'b0, 1,  32'hC000_0000, 32'h0, 5'b00010);
    run("ror",       5'd11, 32'h0000_0001, 32'h0000_0001, 1'b0, 1,  32'h8000_0000, 32'h0, 5'b00010);
    run("shl_zero",  5'd7,  32'h1234_5678, 32'h0000_0020, 1'b0, 1,  32'h1234_5678, 32'h0, 5'b00000);
    run("rol_zero",  5'd10, 32'h8000_0001, 32'h0000_0000, 1'b0, 1,  32'h8000_0001, 32'h0, 5'b00010);
    run("shl_out",   5'd7,  32'h8000_0000, 32'h0000_0001, 1'b0, 1,  32'h0000_0000, 32'h0, 5'b10100);
    run("neg_min",   5'd12, 32'h8000_0000, 32'h0000_0000, 1'b0, 1,  32'h8000_0000, 32'h0, 5'b11010);
    run("pass_a",    5'd20, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1,  32'hDEAD_BEEF, 32'h0, 5'b00010);

    // Back-to-back: SUB then XOR with in_valid held high throughout
    @(negedge clk);
    in_valid = 1'b1; op = 5'd1; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1 op = 5'd5; a = 32'h0000_F0F0; b = 32'h0000_0FF0;
    @(negedge clk);
    chk("b2b_sub_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_sub_lo",    {32'd0, result_lo}, 64'hFFFF_FFFE);
    chk("b2b_sub_flags", {59'd0, flags},     64'b10010);
    chk("b2b_busy",      {63'd0, in_ready},  64'd0);
    @(negedge clk);
    chk("b2b_ready",     {63'd0, in_ready},  64'd1);
    chk("b2b_gap",       {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_xor_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b_xor_lo",    {32'd0, result_lo}, 64'h0000_FF00);
    chk("b2b_xor_flags", {59'd0, flags},     64'd0);

    // Randomized traffic, in_valid toggled freely regardless of in_ready
    repeat (3000) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else                           op = 5'($urandom_range(0, 13));
      a = rnd_word();
      b = rnd_word();
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Reset mid-MUL discards the operation
    run("pre_rst", 5'd0, 32'd1, 32'd1, 1'b0, 1, 32'd2, 32'd0, 5'b00000);
    issue(5'd6, 32'h0000_FFFF, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_lo",        {32'd0, result_lo}, 64'd0);
    chk("midrst_hi",        {32'd0, result_hi}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ov_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("midrst_no_valid", 64'(ov_seen), 64'd0);
    chk("midrst_lo_hold",  {32'd0, result_lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle ALU.
- Keeps the existing op encodings 0–5 (ADD, SUB, DIV, AND, OR, XOR) and adds MUL, shifts, rotates, NEG and NOT.
- Produces a full-width result with a hi/lo pair for MUL/DIV, status flags, and a valid/ready handshake.
- Sits between the register file operand latches and the result register (Z/HI/LO) in the datapath; the control unit issues one op at a time.

Parameters:
- WIDTH, 32, operand/result word width. Must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  op request
- in_ready  output  1  high when the block can accept an op
- op  input  5  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  one-cycle pulse: result and flags are new
- result_lo  output  WIDTH  result / product low / quotient
- result_hi  output  WIDTH  product high / remainder; 0 for other ops
- flag_c  output  1  carry / borrow
- flag_v  output  1  signed overflow
- flag_z  output  1  zero
- flag_n  output  1  negative
- flag_dbz  output  1  divide by zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result_lo=result_hi=0, all flags 0, iteration counter=0. Reset mid-operation discards the op; no out_valid follows.
- Op codes:
  - 0 ADD, 1 SUB, 2 DIV (unsigned, restoring), 3 AND, 4 OR, 5 XOR
  - 6 MUL (unsigned shift-add), 7 SHL, 8 SHR (logical), 9 SHRA (arithmetic), 10 ROL, 11 ROR, 12 NEG (0-a), 13 NOT (~a)
  - 14–31: pass a.
- Shifts/rotates use b[SHW-1:0]; upper bits of b are ignored.
- FSM states IDLE, ITER, DONE:
  - in_ready = (state==IDLE).
  - Accept = in_valid && in_ready at a rising edge; a, b, op are captured at that edge.
  - IDLE → DONE: single-cycle ops, and DIV with b==0. The result is registered at the accept edge.
  - IDLE → ITER: MUL, and DIV with b≠0. Counter loads WIDTH-1.
  - ITER: one partial-product or restoring-subtract step per cycle. Counter decrements; at counter==0 the final step writes result_lo/hi and goes to DONE.
  - DONE: out_valid=1 for exactly one cycle, then IDLE.
- Latency: out_valid is high during cycle N after the accept edge. N=1 for single-cycle ops and DIV-by-zero; N=WIDTH+1 for MUL and DIV. Throughput is at most 1 op per N+1 cycles.
- in_valid while in_ready=0 is ignored (not queued). Operand changes after accept have no effect.
- Result and flag registers hold their values until the next completion, including when out_valid=0.
- result_hi = 0 for all ops except MUL (product[2W-1:W]) and DIV (remainder).
- Flags update only at completion; all flags are 0 except as listed:
  - ADD: c = carry out of bit WIDTH-1; v = signed overflow.
  - SUB and NEG: c = borrow (unsigned a<b; NEG treated as 0-a); v = signed overflow.
  - Shifts: c = last bit shifted out (0 if amount 0).
  - z: result_lo==0 (MUL: full 2W product==0).
  - n: result_lo[WIDTH-1] (MUL: result_hi[WIDTH-1]).
- DIV by zero: flag_dbz=1, result_lo = all ones, result_hi = a, z=0, n=1.
- Rotates by 0 and shifts by 0 return a unchanged.

Test Plan:
- Reset held low mid-MUL (cycle 10 of 32), released → in_ready=1, no out_valid, result_lo=result_hi=0.
- ADD a=0xFFFFFFFF, b=1 → out_valid one cycle after accept; result_lo=0, c=1, z=1, v=0. ADD 0x7FFFFFFF+1 → 0x80000000, v=1, n=1.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF → out_valid exactly 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001. in_valid held high during ITER is not accepted.
- DIV a=100, b=7 → after 33 cycles lo=14, hi=2, dbz=0. DIV a=5, b=0 → after 1 cycle lo=0xFFFFFFFF, hi=5, dbz=1.
- SHRA a=0x80000000, b=0x21 (amount 1) → 0xC0000000, c=0. ROR a=0x00000001, b=1 → 0x80000000, n=1.
- Back-to-back: SUB 3-5 then XOR issued with in_valid held high → SUB result 0xFFFFFFFE with c=1; XOR accepted only once in_ready returns, 2 cycles after the SUB accept.
